slot_digit_gen: RTL and testbench

Per-lane pseudo-random decimal digit generator with 7-segment encoding, feeding the four-digit slot display.
- Each lane owns a 16-bit LFSR.
- The `spin` request reaches each lane through a staggered delay chain, so lanes latch new digits one after another.
- Each latched digit (0-9) is decoded to active-high 7-segment patterns for the display mux.

---
 rtl/slot_digit_gen.sv | 85 ++++++++
 tb/tb_slot_digit_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_digit_gen.sv
// Per-lane LFSR digit generator for the slot display: staggered spin chain,
// mod-10 digit capture and active-high 7-segment decode ({g,f,e,d,c,b,a}).
module slot_digit_gen #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned STAGE_DELAY = 1,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    spin,
  output logic [NUM_DIGITS-1:0]   spin_dly,
  output logic [4*NUM_DIGITS-1:0] digit,
  output logic [7*NUM_DIGITS-1:0] seg
);

  localparam int unsigned CHAIN_LEN = NUM_DIGITS * STAGE_DELAY;
  localparam logic [15:0] POLY      = 16'hB400;

  logic [CHAIN_LEN-1:0] chain;
  logic [15:0]          lfsr     [NUM_DIGITS];
  logic [15:0]          lfsr_nxt [NUM_DIGITS];
  logic [3:0]           cap_dig  [NUM_DIGITS];

  // Lane k starts from SEED rotated left by 4*k so every lane runs its own phase.
  function automatic logic [15:0] seed_for(input int unsigned k);
    int unsigned r;
    r = (4 * k) % 16;
    if (r == 0) return SEED;
    return (SEED << r) | (SEED >> (16 - r));
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Shift form works for a single-flop chain as well as longer ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= (chain << 1) | CHAIN_LEN'(spin);
  end

  always_comb begin
    spin_dly = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++)
      spin_dly[k] = chain[(k + 1) * STAGE_DELAY - 1];
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      lfsr_nxt[k] = lfsr[k][0] ? ((lfsr[k] >> 1) ^ POLY) : (lfsr[k] >> 1);
      cap_dig[k]  = 4'(lfsr[k][7:0] % 8'd10);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) lfsr[k] <= seed_for(k);
      digit <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        lfsr[k] <= lfsr_nxt[k];
        if (spin_dly[k]) digit[4*k +: 4] <= cap_dig[k];
      end
    end
  end

  always_comb begin
    seg = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++)
      seg[7*k +: 7] = seg_of(digit[4*k +: 4]);
  end

endmodule

// File: tb/tb_slot_digit_gen.sv
// Scoreboard bench for slot_digit_gen: two instances (STAGE_DELAY=2/SEED=ACE1 and
// STAGE_DELAY=1/SEED=1) share clk, rst_n and spin; a reference LFSR predicts captures.
module tb_slot_digit_gen;

  localparam int N   = 4;
  localparam int SD0 = 2;
  localparam int SD1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spin = 1'b0;
  logic [N-1:0]   sd0, sd1;
  logic [4*N-1:0] dg0, dg1;
  logic [7*N-1:0] sg0, sg1;

  slot_digit_gen #(.NUM_DIGITS(N), .STAGE_DELAY(SD0), .SEED(16'hACE1)) dut0 (
    .clk(clk), .rst_n(rst_n), .spin(spin), .spin_dly(sd0), .digit(dg0), .seg(sg0));
  slot_digit_gen #(.NUM_DIGITS(N), .STAGE_DELAY(SD1), .SEED(16'h0001)) dut1 (
    .clk(clk), .rst_n(rst_n), .spin(spin), .spin_dly(sd1), .digit(dg1), .seg(sg1));

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         inst;
    int         lane;
    logic [3:0] dig;
  } exp_t;

  exp_t       q[$];
  logic [3:0] expd [2][N];
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] rot(input logic [15:0] v, input int n);
    logic [31:0] dbl;
    dbl = {v, v};
    return dbl[31 - (n % 16) -: 16];
  endfunction

  function automatic int sd_of(input int inst);
    return (inst == 0) ? SD0 : SD1;
  endfunction

  function automatic logic [3:0] dut_dig(input int inst, input int k);
    return (inst == 0) ? dg0[4*k +: 4] : dg1[4*k +: 4];
  endfunction

  function automatic logic [6:0] dut_seg(input int inst, input int k);
    return (inst == 0) ? sg0[7*k +: 7] : sg1[7*k +: 7];
  endfunction

  function automatic logic dut_sd(input int inst, input int k);
    return (inst == 0) ? sd0[k] : sd1[k];
  endfunction

  // Reference LFSRs and record of spin as sampled at each rising edge.
  logic [15:0] mdl [2][N];
  int          ec = 64;
  logic        ring [64];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        mdl[0][k] <= rot(16'hACE1, 4 * k);
        mdl[1][k] <= rot(16'h0001, 4 * k);
      end else begin
        mdl[0][k] <= lstep(mdl[0][k]);
        mdl[1][k] <= lstep(mdl[1][k]);
      end
    end
  end

  always @(posedge clk) begin
    ec <= ec + 1;
    if (!rst_n) for (int j = 0; j < 64; j++) ring[j] <= 1'b0;
    else        ring[(ec + 1) % 64] <= spin;
  end

  // One cycle: drive spin, predict captures, then score at the falling edge.
  task automatic drive(input logic s);
    @(posedge clk);
    #1;
    spin = s;
    if (s && rst_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < N; k++) begin
          exp_t        e;
          logic [15:0] v;
          int          d;
          d = (k + 1) * sd_of(i);
          v = mdl[i][k];
          repeat (d) v = lstep(v);
          e.due  = ec + 1 + d;
          e.inst = i;
          e.lane = k;
          e.dig  = 4'(v[7:0] % 8'd10);
          q.push_back(e);
        end
      end
    end
    @(negedge clk);
    for (int j = q.size() - 1; j >= 0; j--) begin
      if (q[j].due == ec) begin
        expd[q[j].inst][q[j].lane] = q[j].dig;
        q.delete(j);
      end
    end
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < N; k++) begin
        logic esd;
        esd = rst_n ? ring[(ec - (k + 1) * sd_of(i) + 1) % 64] : 1'b0;
        checks++;
        if (dut_dig(i, k) !== expd[i][k]) begin
          errors++;
          $display("FAIL sb_digit inst%0d lane%0d ec=%0d got %0d exp %0d", i, k, ec, dut_dig(i, k), expd[i][k]);
        end
        checks++;
        if (dut_seg(i, k) !== seg_tab[expd[i][k]]) begin
          errors++;
          $display("FAIL sb_seg inst%0d lane%0d ec=%0d got %h exp %h", i, k, ec, dut_seg(i, k), seg_tab[expd[i][k]]);
        end
        checks++;
        if (dut_sd(i, k) !== esd) begin
          errors++;
          $display("FAIL sb_spin_dly inst%0d lane%0d ec=%0d got %b exp %b", i, k, ec, dut_sd(i, k), esd);
        end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({sd1, sd0} !== '0) begin
      errors++;
      $display("FAIL %s_spin_dly got %h exp 0", tag, {sd1, sd0});
    end
    checks++;
    if ({dg1, dg0} !== '0) begin
      errors++;
      $display("FAIL %s_digit got %h exp 0", tag, {dg1, dg0});
    end
    checks++;
    if (sg0 !== {N{7'h3F}} || sg1 !== {N{7'h3F}}) begin
      errors++;
      $display("FAIL %s_seg got %h/%h exp %h", tag, sg0, sg1, {N{7'h3F}});
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) for (int k = 0; k < N; k++) expd[i][k] = 4'd0;
    rst_n = 1'b0;
    spin  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) drive(1'b0);
    check_reset_values("idle");
  endtask

  task automatic test_delay_stagger();
    int n;
    drive(1'b1);
    n = ec;
    for (int c = 0; c < 12; c++) begin
      logic [N-1:0] exp_sd;
      drive(1'b0);
      for (int k = 0; k < N; k++) exp_sd[k] = (ec == n + 2 * k + 2);
      checks++;
      if (sd0 !== exp_sd) begin
        errors++;
        $display("FAIL stagger_spin_dly ec=%0d got %b exp %b", ec - n, sd0, exp_sd);
      end
    end
  endtask

  task automatic test_lfsr_seq();
    logic [3:0] fin [N];
    repeat (300) drive(1'b1);
    for (int k = 0; k < N; k++) begin
      logic [15:0] v;
      v = mdl[0][k];
      repeat (2 * (k + 1)) v = lstep(v);
      fin[k] = 4'(v[7:0] % 8'd10);
    end
    repeat (12) drive(1'b0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (dg0[4*k +: 4] !== fin[k]) begin
        errors++;
        $display("FAIL lfsr_final lane%0d got %0d exp %0d", k, dg0[4*k +: 4], fin[k]);
      end
    end
  endtask

  task automatic test_decode_range();
    int hist [N][10];
    for (int k = 0; k < N; k++) for (int v = 0; v < 10; v++) hist[k][v] = 0;
    repeat (10000) begin
      drive(1'b1);
      for (int k = 0; k < N; k++) begin
        logic [3:0] d;
        d = dg0[4*k +: 4];
        checks++;
        if (d > 4'd9) begin
          errors++;
          $display("FAIL range lane%0d got %0d exp 0..9", k, d);
        end else begin
          hist[k][d]++;
        end
      end
    end
    repeat (12) drive(1'b0);
    for (int k = 0; k < N; k++) begin
      for (int v = 0; v < 10; v++) begin
        checks++;
        if (hist[k][v] < 800 || hist[k][v] > 1200) begin
          errors++;
          $display("FAIL histogram lane%0d digit%0d got %0d exp 800..1200", k, v, hist[k][v]);
        end
      end
    end
  endtask

  task automatic test_toggle();
    logic pat [64];
    for (int i = 0; i < 64; i++) begin
      logic s;
      s = (i < 60) ? 1'($urandom_range(0, 1)) : 1'b0;
      pat[i] = s;
      drive(s);
      for (int inst = 0; inst < 2; inst++) begin
        for (int k = 0; k < N; k++) begin
          int   src;
          logic e;
          src = i - (k + 1) * sd_of(inst);
          e   = (src >= 0) ? pat[src] : 1'b0;
          checks++;
          if (dut_sd(inst, k) !== e) begin
            errors++;
            $display("FAIL toggle_spin_dly inst%0d lane%0d step%0d got %b exp %b", inst, k, i, dut_sd(inst, k), e);
          end
        end
      end
    end
    repeat (12) drive(1'b0);
  endtask

  task automatic test_async_reset();
    repeat (5) drive(1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    q.delete();
    for (int i = 0; i < 2; i++) for (int k = 0; k < N; k++) expd[i][k] = 4'd0;
    #1 check_reset_values("async");
    spin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) drive(1'b0);
    check_reset_values("post_async");
  endtask

  task automatic test_lane_independence();
    logic [3:0] fin [N];
    drive(1'b1);
    for (int k = 0; k < N; k++) begin
      logic [15:0] v;
      v = mdl[1][k];
      repeat (k + 1) v = lstep(v);
      fin[k] = 4'(v[7:0] % 8'd10);
    end
    repeat (8) drive(1'b0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (dg1[4*k +: 4] !== fin[k]) begin
        errors++;
        $display("FAIL lane_indep lane%0d got %0d exp %0d", k, dg1[4*k +: 4], fin[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_delay_stagger();
    test_lfsr_seq();
    test_decode_range();
    test_toggle();
    test_async_reset();
    test_lane_independence();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
